// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared SHA-256 constants and helpers for the SHA256d nonce scheduler:
//   SHA256_IV            - initial hash value H0..H7, packed {a..h}
//   PAD_WORD             - first padding word (single 1 bit after the message)
//   LEN_80B / LEN_32B    - low length words for an 80-byte header / 32-byte hash
//   HASH_BYTES           - digest size in bytes
//   sched_state_e        - scheduler FSM states
//   bswap32()            - 32-bit byte swap
package sha256_pkg;

    localparam int HASH_BYTES = 32;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] PAD_WORD = 32'h80000000;
    localparam logic [31:0] LEN_80B  = 32'h00000280;
    localparam logic [31:0] LEN_32B  = 32'h00000100;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_C1_START,
        ST_C1_WAIT,
        ST_C2_START,
        ST_C2_WAIT,
        ST_CHECK,
        ST_REPORT,
        ST_NEXT,
        ST_DRAIN
    } sched_state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256d_target_cmp.sv
// sha256d_target_cmp
// Combinational target compare for a finished SHA256d digest.
//   h2_i      - second-pass digest, packed {a..h} (big-endian words)
//   target_i  - 256-bit unsigned target
//   hash_le_o - h2_i with all 32 bytes reversed (display/compare order)
//   hit_o     - hash_le_o <= target_i
module sha256d_target_cmp
    import sha256_pkg::*;
(
    input  logic [255:0] h2_i,
    input  logic [255:0] target_i,
    output logic [255:0] hash_le_o,
    output logic         hit_o
);

    always_comb begin
        hash_le_o = '0;
        for (int b = 0; b < HASH_BYTES; b++) begin
            hash_le_o[8*b +: 8] = h2_i[8*(HASH_BYTES-1-b) +: 8];
        end
    end

    assign hit_o = (hash_le_o <= target_i);

endmodule

// File: rtl/sha256d_nonce_scheduler.sv
// sha256d_nonce_scheduler
// Drives one SHA-256 compression core through SHA256d(header) for every nonce
// of a job range [first..last] (inclusive, 32-bit wrapping), compares each
// result against the job target and reports hits.
//   clk, rst                 - clock, asynchronous active-high reset
//   job_*                    - job offer (valid/ready) with midstate, tail, range, target
//   abort                    - terminate the current job
//   found_*                  - hit report (valid/ready), nonce and byte-reversed hash
//   job_done / job_aborted   - end-of-job pulse and its cause
//   core_*                   - control/data to and from the compression core
//   hash_count               - completed SHA256d count (SHA256D_SCHED_STATS_EN only)
// Optional feature macro: SHA256D_SCHED_STATS_EN.
module sha256d_nonce_scheduler
    import sha256_pkg::*;
#(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [255:0]       job_midstate,
    input  logic [95:0]        job_tail,
    input  logic [NONCE_W-1:0] job_nonce_first,
    input  logic [NONCE_W-1:0] job_nonce_last,
    input  logic [255:0]       job_target,
    input  logic               abort,
    output logic               found_valid,
    input  logic               found_ready,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [255:0]       found_hash,
    output logic               job_done,
    output logic               job_aborted,
`ifdef SHA256D_SCHED_STATS_EN
    output logic [31:0]        hash_count,
`endif
    output logic               core_start,
    output logic [255:0]       core_state_i,
    output logic [511:0]       core_block_i,
    input  logic               core_busy,
    input  logic               core_done,
    input  logic [255:0]       core_state_o
);

    sched_state_e       state_q, state_d;
    logic               init_q;
    logic [255:0]       midstate_q, target_q, h1_q, h2_q, hash_q;
    logic [95:0]        tail_q;
    logic [NONCE_W-1:0] nonce_q, last_q;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               load_job, latch_h1, latch_h2, latch_hash, nonce_inc;
    logic [255:0]       hash_le;
    logic               hit;

    sha256d_target_cmp u_cmp (
        .h2_i      (h2_q),
        .target_i  (target_q),
        .hash_le_o (hash_le),
        .hit_o     (hit)
    );

    // init_q keeps job_ready low while reset is held; done_q masks the
    // IDLE cycle carrying the job_done pulse.
    assign job_ready   = init_q && !done_q && (state_q == ST_IDLE);
    assign found_valid = (state_q == ST_REPORT);
    assign found_nonce = nonce_q;
    assign found_hash  = hash_q;
    assign job_done    = done_q;
    assign job_aborted = aborted_q;

    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        load_job   = 1'b0;
        latch_h1   = 1'b0;
        latch_h2   = 1'b0;
        latch_hash = 1'b0;
        nonce_inc  = 1'b0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (job_valid && job_ready) begin
                    load_job = 1'b1;
                    state_d  = ST_C1_START;
                end
            end
            ST_C1_START, ST_C2_START: begin
                // Abort suppresses the start so nothing is left running.
                if (abort) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (!core_busy) begin
                    core_start = 1'b1;
                    state_d    = (state_q == ST_C1_START) ? ST_C1_WAIT : ST_C2_WAIT;
                end
            end
            ST_C1_WAIT, ST_C2_WAIT: begin
                if (abort && core_done) begin
                    // Core finished in the same cycle: nothing left to drain.
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (abort) begin
                    state_d = ST_DRAIN;
                end else if (core_done) begin
                    latch_h1 = (state_q == ST_C1_WAIT);
                    latch_h2 = (state_q == ST_C2_WAIT);
                    state_d  = (state_q == ST_C1_WAIT) ? ST_C2_START : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    latch_hash = 1'b1;
                    state_d    = hit ? ST_REPORT : ST_NEXT;
                end
            end
            ST_REPORT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (found_ready) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (nonce_q == last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    nonce_inc = 1'b1;
                    state_d   = ST_C1_START;
                end
            end
            ST_DRAIN: begin
                if (core_done) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Core inputs are a pure function of registered state so they stay
    // stable from each START through its WAIT. The 10-word zero run in the
    // first block includes the high word of the 64-bit length field.
    always_comb begin
        core_state_i = '0;
        core_block_i = '0;
        case (state_q)
            ST_C1_START, ST_C1_WAIT: begin
                core_state_i = midstate_q;
                core_block_i = {tail_q, bswap32(nonce_q), PAD_WORD, 320'h0, LEN_80B};
            end
            ST_C2_START, ST_C2_WAIT: begin
                core_state_i = SHA256_IV;
                core_block_i = {h1_q, PAD_WORD, 192'h0, LEN_32B};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            init_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            midstate_q <= '0;
            tail_q     <= '0;
            nonce_q    <= '0;
            last_q     <= '0;
            target_q   <= '0;
            h1_q       <= '0;
            h2_q       <= '0;
            hash_q     <= '0;
        end else begin
            state_q   <= state_d;
            init_q    <= 1'b1;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            if (load_job) begin
                midstate_q <= job_midstate;
                tail_q     <= job_tail;
                nonce_q    <= job_nonce_first;
                last_q     <= job_nonce_last;
                target_q   <= job_target;
            end else if (nonce_inc) begin
                nonce_q <= nonce_q + NONCE_W'(1);
            end
            if (latch_h1)   h1_q   <= core_state_o;
            if (latch_h2)   h2_q   <= core_state_o;
            if (latch_hash) hash_q <= hash_le;
        end
    end

`ifdef SHA256D_SCHED_STATS_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (state_q == ST_CHECK) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign hash_count = count_q;
`endif

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Self-checking bench for sha256d_nonce_scheduler with a behavioural
// SHA-256 compression core and a reference SHA256d model.
module tb_sha256d_nonce_scheduler;

    localparam int LAT = 16;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [511:0] GEN_HEAD0 = {32'h01000000, 256'h0,
        224'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa};
    localparam logic [95:0]  GEN_TAIL = {32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d};
    localparam logic [255:0] GEN_HASH = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] GEN_TGT  = {32'h0, 16'hffff, 208'h0};

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid, job_ready, abort, found_valid, found_ready;
    logic [255:0] job_midstate, job_target, found_hash;
    logic [95:0]  job_tail;
    logic [31:0]  job_nonce_first, job_nonce_last, found_nonce;
    logic         job_done, job_aborted, core_start, core_busy, core_done;
    logic [255:0] core_state_i, core_state_o;
    logic [511:0] core_block_i;
`ifdef SHA256D_SCHED_STATS_EN
    logic [31:0]  hash_count;
`endif

    always #5 clk = ~clk;

    sha256d_nonce_scheduler dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_midstate(job_midstate), .job_tail(job_tail),
        .job_nonce_first(job_nonce_first), .job_nonce_last(job_nonce_last),
        .job_target(job_target), .abort(abort),
        .found_valid(found_valid), .found_ready(found_ready),
        .found_nonce(found_nonce), .found_hash(found_hash),
        .job_done(job_done), .job_aborted(job_aborted),
`ifdef SHA256D_SCHED_STATS_EN
        .hash_count(hash_count),
`endif
        .core_start(core_start), .core_state_i(core_state_i), .core_block_i(core_block_i),
        .core_busy(core_busy), .core_done(core_done), .core_state_o(core_state_o)
    );

    // ---------------- reference SHA-256 ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = st;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
                st[127:96] + e,  st[95:64] + f,   st[63:32] + g,   st[31:0] + h};
    endfunction

    function automatic logic [31:0] bsw(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    logic [255:0] g_mid;

    function automatic logic [255:0] sha256d_le(input logic [31:0] nonce);
        logic [255:0] h1, h2, r;
        h1 = compress(g_mid, {GEN_TAIL, bsw(nonce), 32'h80000000, 320'h0, 32'h280});
        h2 = compress(IV, {h1, 32'h80000000, 192'h0, 32'h100});
        for (int i = 0; i < 32; i++) r[8*i +: 8] = h2[8*(31-i) +: 8];
        return r;
    endfunction

    // ---------------- behavioural compression core ----------------
    logic [4:0]   cm_cnt;
    logic         cm_busy, cm_done;
    logic [255:0] cm_res, cm_out;
    int           bad_start = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_cnt <= '0; cm_busy <= 1'b0; cm_done <= 1'b0; cm_res <= '0; cm_out <= '0;
        end else begin
            cm_done <= 1'b0;
            if (core_start && cm_busy) bad_start <= bad_start + 1;
            if (core_start && !cm_busy) begin
                cm_busy <= 1'b1;
                cm_cnt  <= 5'(LAT - 1);
                cm_res  <= compress(core_state_i, core_block_i);
            end else if (cm_busy) begin
                if (cm_cnt == 0) begin
                    cm_busy <= 1'b0; cm_done <= 1'b1; cm_out <= cm_res;
                end else begin
                    cm_cnt <= cm_cnt - 5'd1;
                end
            end
        end
    end
    assign core_busy    = cm_busy;
    assign core_done    = cm_done;
    assign core_state_o = cm_out;

    // ---------------- checking ----------------
    int checks = 0, failures = 0;

    typedef struct packed { logic [31:0] nonce; logic [255:0] hash; } hit_t;
    hit_t exp_q [$];

    typedef struct {
        logic [31:0]  first, last;
        logic [255:0] target;
        int           stall, exp_hits, exp_nonces;
        logic [31:0]  exp_first_hit;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic offer(input logic [31:0] first, input logic [31:0] last, input logic [255:0] tgt);
        int cyc = 0;
        while (!job_ready && cyc < 60) begin tick(); cyc++; end
        chk("job_ready_before_offer", job_ready, 1'b1);
        job_midstate = g_mid; job_tail = GEN_TAIL;
        job_nonce_first = first; job_nonce_last = last; job_target = tgt;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk("core_start_after_accept", core_start, 1'b1);
    endtask

    task automatic run_job(input vec_t v);
        int starts = 0, hits = 0, stall = 0, k;
        bit done_seen = 0, stall_bad = 0;
        logic [31:0] nc, exp_n, first_hit = '0, hold_n = '0;
        logic [255:0] hl, hold_h = '0;
        hit_t e;
        exp_q.delete();
        nc = v.first;
        for (k = 0; k < 1000; k++) begin
            hl = sha256d_le(nc);
            if (hl <= v.target) exp_q.push_back({nc, hl});
            if (nc == v.last) break;
            nc = nc + 32'd1;
        end
        offer(v.first, v.last, v.target);
        for (int c = 0; c < 5000 && !done_seen; c++) begin
            if (c != 0) tick();
            found_ready = 1'b0;
            if (core_start) begin
                if (starts % 2 == 0) begin
                    exp_n = v.first + 32'(starts / 2);
                    chk("c1_nonce_word", core_block_i[415:384], bsw(exp_n));
                end
                starts++;
                if (found_valid) stall_bad = 1;
            end
            if (found_valid) begin
                if (stall == 0) begin
                    hold_n = found_nonce; hold_h = found_hash;
                end else if (found_nonce != hold_n || found_hash != hold_h) begin
                    stall_bad = 1;
                end
                if (stall >= v.stall) begin
                    found_ready = 1'b1;
                    if (hits == 0) first_hit = found_nonce;
                    hits++;
                    stall = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_hit_nonce", found_nonce, 32'hx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hit_nonce", found_nonce, e.nonce);
                        chk("hit_hash", found_hash, e.hash);
                    end
                end else begin
                    stall++;
                end
            end
            if (job_done) begin
                done_seen = 1;
                chk("job_aborted_on_done", job_aborted, 1'b0);
            end
        end
        found_ready = 1'b0;
        chk("job_done_seen", done_seen, 1'b1);
        chk("hit_count", hits, v.exp_hits);
        chk("core_start_count", starts, 2 * v.exp_nonces);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("stall_stable_no_start", stall_bad, 1'b0);
        if (v.exp_hits > 0) chk("first_hit_nonce", first_hit, v.exp_first_hit);
        tick();
        chk("job_ready_after_done", {job_ready, job_done}, 2'b10);
    endtask

    initial begin
        bit seen;
        vecs[0] = '{32'h7c2bac1a, 32'h7c2bac20, GEN_TGT, 0, 1, 7, 32'h7c2bac1d};
        vecs[1] = '{32'd5, 32'd7, {256{1'b1}}, 20, 3, 3, 32'd5};
        vecs[2] = '{32'hfffffffe, 32'h00000001, 256'h0, 0, 0, 4, 32'h0};
        vecs[3] = '{32'd200, 32'd201, {256{1'b1}}, 0, 2, 2, 32'd200};

        rst = 1'b1; job_valid = 1'b0; abort = 1'b0; found_ready = 1'b0;
        job_midstate = '0; job_tail = '0; job_nonce_first = '0; job_nonce_last = '0; job_target = '0;
        g_mid = compress(IV, GEN_HEAD0);
        #3;
        chk("reset_ctrl", {job_ready, core_start, found_valid, job_done, job_aborted}, 5'b0);
        chk("reset_data", {core_state_i, core_block_i, found_nonce, found_hash}, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("ready_low_before_edge", job_ready, 1'b0);
        tick();
        chk("ready_after_reset", job_ready, 1'b1);
        chk("model_genesis_hash", sha256d_le(32'h7c2bac1d), GEN_HASH);

        for (int i = 0; i < 3; i++) run_job(vecs[i]);

        // abort in C1_WAIT: drain the core, then report an aborted end
        offer(32'd0, 32'd100, 256'h0);
        for (int i = 0; i < 10; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (i != 0) tick();
            if (core_start) chk("no_start_during_drain", core_start, 1'b0);
            if (core_done) seen = 1;
        end
        chk("drain_core_done_seen", seen, 1'b1);
        tick();
        chk("abort_done_pulse", {job_done, job_aborted, job_ready}, 3'b110);
        tick();
        chk("abort_ready_next", {job_done, job_ready}, 2'b01);

        // asynchronous reset while in C2_WAIT
        offer(32'd50, 32'd60, {256{1'b1}});
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (core_start && core_state_i == IV) seen = 1;
        end
        chk("c2_start_seen", seen, 1'b1);
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("midrun_reset_ctrl", {job_ready, core_start, found_valid, job_done, job_aborted}, 5'b0);
        chk("midrun_reset_data", {core_state_i, core_block_i, found_nonce, found_hash}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        run_job(vecs[3]);

`ifdef SHA256D_SCHED_STATS_EN
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        run_job('{32'd0, 32'd9, 256'h0, 0, 0, 10, 32'h0});
        chk("hash_count", hash_count, 32'd10);
`endif

        chk("never_start_while_busy", bad_start, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
